// File: rtl/pipe_pkg.sv
// Shared widths and control-bus bit positions for the pipeline stage registers.
// Every stage instance uses these so the control fields line up from stage to stage.
package pipe_pkg;

  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CTRL_W = 8;

  localparam int CTRL_REGWRITE     = 0;
  localparam int CTRL_MEMREAD      = 1;
  localparam int CTRL_MEMWRITE     = 2;
  localparam int CTRL_MEMTOREG_LSB = 3;
  localparam int CTRL_MEMTOREG_MSB = 4;

  // True when a control word would change architectural state downstream.
  function automatic logic ctrl_has_side_effect(input logic [PIPE_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a stage register: valid flag, payload and control word.
// Flush beats load, and it also zeroes the control word so a squashed slot is a clean bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready inter-stage register for the 5-stage pipeline, with an optional
// skid entry that keeps the upstream ready fully registered at full throughput.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iValid,
  output logic              oInReady,
  input  logic [DATA_W-1:0] iData,
  input  logic [CTRL_W-1:0] iCtrl,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iOutReady,
  output logic [DATA_W-1:0] oData,
  output logic [CTRL_W-1:0] oCtrl,
  output logic [1:0]        oCount
);

  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data,  m_in_data;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl,  m_in_ctrl;
  logic              m_load, m_clear, m_from_s, s_load, s_clear;
  logic              m_valid_d, s_valid_d;
  logic              accept, emit;
  logic [1:0]        count_d, count_q;

  assign accept = iValid & oInReady;
  assign emit   = m_valid & iOutReady;

  always_comb begin
    m_load    = 1'b0;
    m_clear   = 1'b0;
    m_from_s  = 1'b0;
    s_load    = 1'b0;
    s_clear   = 1'b0;
    m_valid_d = m_valid;
    s_valid_d = s_valid;
    if (SKID != 0) begin
      if (!m_valid) begin
        if (accept) begin
          m_load    = 1'b1;
          m_valid_d = 1'b1;
        end
      end else if (s_valid) begin
        // S drains into M first; upstream is held off, so nothing can arrive this cycle.
        if (emit) begin
          m_load    = 1'b1;
          m_from_s  = 1'b1;
          s_clear   = 1'b1;
          s_valid_d = 1'b0;
        end
      end else if (emit && accept) begin
        m_load = 1'b1;
      end else if (emit) begin
        m_clear   = 1'b1;
        m_valid_d = 1'b0;
      end else if (accept) begin
        s_load    = 1'b1;
        s_valid_d = 1'b1;
      end
    end else begin
      if (accept) begin
        m_load    = 1'b1;
        m_valid_d = 1'b1;
      end else if (emit) begin
        m_clear   = 1'b1;
        m_valid_d = 1'b0;
      end
    end
    if (iFlush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
    count_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  assign m_in_data = m_from_s ? s_data : iData;
  assign m_in_ctrl = m_from_s ? s_ctrl : iCtrl;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_m (
    .clk    (clk),
    .rst_n  (reset),
    .load   (m_load),
    .clear  (m_clear),
    .flush  (iFlush),
    .d_data (m_in_data),
    .d_ctrl (m_in_ctrl),
    .valid  (m_valid),
    .data   (m_data),
    .ctrl   (m_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_d, in_ready_q;

      assign in_ready_d = ~s_valid_d;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_s (
        .clk    (clk),
        .rst_n  (reset),
        .load   (s_load),
        .clear  (s_clear),
        .flush  (iFlush),
        .d_data (iData),
        .d_ctrl (iCtrl),
        .valid  (s_valid),
        .data   (s_data),
        .ctrl   (s_ctrl)
      );

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_ready_q <= 1'b1;
        else        in_ready_q <= in_ready_d;
      end

      assign oInReady = in_ready_q;
    end else begin : g_single
      assign s_valid  = 1'b0;
      assign s_data   = '0;
      assign s_ctrl   = '0;
      assign oInReady = ~m_valid | iOutReady;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  assign oValid = m_valid;
  assign oData  = m_data;
  assign oCtrl  = m_valid ? m_ctrl : '0;
  assign oCount = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage register with identical stimulus and compares
// both against a queue-based FIFO reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = PIPE_DATA_W;
  localparam int CW = PIPE_CTRL_W;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i, flush_i, out_ready_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] ctrl_i;

  logic          in_ready1, valid1, in_ready0, valid0;
  logic [DW-1:0] data1, data0;
  logic [CW-1:0] ctrl1, ctrl0;
  logic [1:0]    count1, count0;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t q1[$];
  ent_t q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .iValid(valid_i), .oInReady(in_ready1),
    .iData(data_i), .iCtrl(ctrl_i), .iFlush(flush_i), .oValid(valid1),
    .iOutReady(out_ready_i), .oData(data1), .oCtrl(ctrl1), .oCount(count1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .iValid(valid_i), .oInReady(in_ready0),
    .iData(data_i), .iCtrl(ctrl_i), .iFlush(flush_i), .oValid(valid0),
    .iOutReady(out_ready_i), .oData(data0), .oCtrl(ctrl0), .oCount(count0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model view: capacity 2 with ready = room left (SKID=1); capacity 1 with
  // ready = empty or leaving this cycle (SKID=0).
  function automatic logic ready1_exp();
    return q1.size() < 2;
  endfunction

  function automatic logic ready0_exp();
    return (q0.size() == 0) || out_ready_i;
  endfunction

  task automatic check_all();
    chk("s1.ready", DW'(in_ready1), DW'(ready1_exp()));
    chk("s1.valid", DW'(valid1), DW'(q1.size() != 0));
    chk("s1.count", DW'(count1), DW'(q1.size()));
    chk("s1.ctrl",  DW'(ctrl1), (q1.size() != 0) ? DW'(q1[0].c) : '0);
    if (q1.size() != 0) chk("s1.data", data1, q1[0].d);
    chk("s0.ready", DW'(in_ready0), DW'(ready0_exp()));
    chk("s0.valid", DW'(valid0), DW'(q0.size() != 0));
    chk("s0.count", DW'(count0), DW'(q0.size()));
    chk("s0.ctrl",  DW'(ctrl0), (q0.size() != 0) ? DW'(q0[0].c) : '0);
    if (q0.size() != 0) chk("s0.data", data0, q0[0].d);
  endtask

  // Checks current outputs, clocks once, then advances both models.
  task automatic tick();
    logic acc1, acc0, em1, em0;
    ent_t e;
    #1;
    check_all();
    acc1 = valid_i & ready1_exp();
    acc0 = valid_i & ready0_exp();
    em1  = (q1.size() != 0) & out_ready_i;
    em0  = (q0.size() != 0) & out_ready_i;
    e.d  = data_i;
    e.c  = ctrl_i;
    @(posedge clk);
    if (em1) void'(q1.pop_front());
    if (em0) void'(q0.pop_front());
    if (flush_i) begin
      q1.delete();
      q0.delete();
    end else begin
      if (acc1) q1.push_back(e);
      if (acc0) q0.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic rdy, input logic fl);
    valid_i     = v;
    data_i      = d;
    ctrl_i      = c;
    out_ready_i = rdy;
    flush_i     = fl;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i), CW'(i * 3), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    tick();

    // Stall: the skid stage fills to two, the single stage holds one.
    drive(1'b1, 64'hA, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hB, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hD, 8'h33, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    // Flush a full stage while a new instruction is offered.
    drive(1'b1, 64'hA, 8'h11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hB, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hC, 8'hFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush.s1_ready", DW'(in_ready1), DW'(1));
    repeat (2) tick();

    // Bubble control: control bits show for exactly one cycle.
    drive(1'b1, 64'h55, 8'hFF, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("bubble.ctrl_live", DW'(ctrl1), DW'(8'hFF));
    tick();
    chk("bubble.ctrl_zero", DW'(ctrl1), '0);
    chk("bubble.side_eff", DW'(ctrl_has_side_effect(ctrl1)), '0);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 64'h77, 8'h0F, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h78, 8'hF0, 1'b0, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    chk("areset.s1_valid", DW'(valid1), '0);
    chk("areset.s1_count", DW'(count1), '0);
    chk("areset.s1_ctrl",  DW'(ctrl1), '0);
    chk("areset.s1_ready", DW'(in_ready1), DW'(1));
    chk("areset.s0_valid", DW'(valid0), '0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();

    // Single-entry stage: ready follows downstream ready within the cycle.
    drive(1'b1, 64'h90, 8'h01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h91, 8'h02, 1'b0, 1'b0);
    #1;
    chk("s0.stall_ready", DW'(in_ready0), '0);
    out_ready_i = 1'b1;
    #1;
    chk("s0.pass_ready", DW'(in_ready0), DW'(1));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(64'h92 + i), CW'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, CW'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
